// File: rtl/cpu_types_pkg.sv
// Shared CPU types: hazard controller state and performance counter width.
package cpu_types_pkg;

  localparam int unsigned CNT_W_DEFAULT = 32;
  localparam int unsigned REG_W         = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/hazard_perf_counters.sv
// Wrapping stall and flush event counters for the hazard controller.
module hazard_perf_counters #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             stall_inc,
  input  logic             flush_inc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_inc) stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_inc) flush_count  <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller for the five-stage pipeline: resolves cache misses,
// load-use hazards, redirects and halt, and counts stall/flush events.
module hazard_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemREN_mem,
  input  logic             dmemWEN_mem,
  input  logic             memread_ex,
  input  logic             regwen_ex,
  input  logic [REG_W-1:0] rd_ex,
  input  logic [REG_W-1:0] rs_dec,
  input  logic [REG_W-1:0] rt_dec,
  input  logic             redirect_ex,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             en_fd,
  output logic             en_de,
  output logic             en_em,
  output logic             en_mw,
  output logic             flush_fd,
  output logic             flush_de,
  output logic             flush_em,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  hazard_state_t state, next_state;
  logic dreq, lu, freeze, flush_inc, stall_inc;

  assign dreq = dmemREN_mem | dmemWEN_mem;
  assign lu   = memread_ex & regwen_ex & (rd_ex != REG_W'(0)) &
                ((rd_ex == rs_dec) | (rd_ex == rt_dec));
  // Once waiting, only dhit releases; redirect and lu are held off until then.
  assign freeze    = (state == DWAIT) ? ~dhit : (dreq & ~dhit);
  assign stall_inc = (state != HALT) & ~pc_en;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= next_state;
  end

  // Priority: halt, data miss, redirect, load-use, instruction miss, run.
  always_comb begin
    next_state = state;
    pc_en      = 1'b0;
    en_fd      = 1'b0;
    en_de      = 1'b0;
    en_em      = 1'b0;
    en_mw      = 1'b0;
    flush_fd   = 1'b0;
    flush_de   = 1'b0;
    flush_em   = 1'b0;
    halt       = 1'b0;
    flush_inc  = 1'b0;
    if (state == HALT || halt_wb) begin
      halt       = 1'b1;
      next_state = HALT;
    end else if (freeze) begin
      next_state = DWAIT;
    end else begin
      next_state = RUN;
      en_em      = 1'b1;
      en_mw      = 1'b1;
      if (redirect_ex) begin
        pc_en     = 1'b1;
        flush_fd  = 1'b1;
        flush_de  = 1'b1;
        flush_inc = 1'b1;
      end else if (lu) begin
        flush_de = 1'b1;
      end else if (!ihit) begin
        flush_fd = 1'b1;
        en_de    = 1'b1;
      end else begin
        pc_en = 1'b1;
        en_fd = 1'b1;
        en_de = 1'b1;
      end
    end
  end

  hazard_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .CLK          (CLK),
    .nRST         (nRST),
    .stall_inc    (stall_inc),
    .flush_inc    (flush_inc),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_hazard_unit;

  logic CLK = 1'b0;
  logic nRST;
  logic ihit, dhit, dmemREN_mem, dmemWEN_mem, memread_ex, regwen_ex;
  logic [4:0] rd_ex, rs_dec, rt_dec;
  logic redirect_ex, halt_wb;

  logic pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em, halt;
  logic [31:0] stall_cycles, flush_count;
  logic pc_en4, en_fd4, en_de4, en_em4, en_mw4, flush_fd4, flush_de4, flush_em4, halt4;
  logic [3:0] stall4, flush4;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_on = 1'b0;

  always #5 CLK = ~CLK;

  hazard_unit dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dmemREN_mem(dmemREN_mem), .dmemWEN_mem(dmemWEN_mem),
    .memread_ex(memread_ex), .regwen_ex(regwen_ex),
    .rd_ex(rd_ex), .rs_dec(rs_dec), .rt_dec(rt_dec),
    .redirect_ex(redirect_ex), .halt_wb(halt_wb),
    .pc_en(pc_en), .en_fd(en_fd), .en_de(en_de), .en_em(en_em), .en_mw(en_mw),
    .flush_fd(flush_fd), .flush_de(flush_de), .flush_em(flush_em), .halt(halt),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  hazard_unit #(.CNT_W(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dmemREN_mem(dmemREN_mem), .dmemWEN_mem(dmemWEN_mem),
    .memread_ex(memread_ex), .regwen_ex(regwen_ex),
    .rd_ex(rd_ex), .rs_dec(rs_dec), .rt_dec(rt_dec),
    .redirect_ex(redirect_ex), .halt_wb(halt_wb),
    .pc_en(pc_en4), .en_fd(en_fd4), .en_de(en_de4), .en_em(en_em4), .en_mw(en_mw4),
    .flush_fd(flush_fd4), .flush_de(flush_de4), .flush_em(flush_em4), .halt(halt4),
    .stall_cycles(stall4), .flush_count(flush4)
  );

  // Strobe vector order: pc_en en_fd en_de en_em en_mw flush_fd flush_de flush_em halt
  typedef struct packed {
    logic [8:0] strobes;
    logic       redir;
  } exp_t;

  function automatic exp_t model(bit halted, bit waiting);
    exp_t e;
    bit dreq, lu;
    e = '0;
    dreq = dmemREN_mem || dmemWEN_mem;
    lu = memread_ex && regwen_ex && rd_ex != 0 && (rd_ex == rs_dec || rd_ex == rt_dec);
    if (halted || halt_wb) e.strobes = 9'b0_0000_0001;
    else if (waiting ? !dhit : (dreq && !dhit)) e.strobes = 9'b0;
    else if (redirect_ex) begin e.strobes = 9'b1_0011_1100; e.redir = 1'b1; end
    else if (lu) e.strobes = 9'b0_0011_0100;
    else if (!ihit) e.strobes = 9'b0_0111_1000;
    else e.strobes = 9'b1_1111_0000;
    return e;
  endfunction

  // Model state: halted flag, outstanding-miss flag and event tallies.
  bit m_halted, m_wait;
  logic [31:0] m_stall, m_flush;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_halted <= 1'b0; m_wait <= 1'b0; m_stall <= '0; m_flush <= '0;
    end else begin
      exp_t e;
      e = model(m_halted, m_wait);
      if (!m_halted && !e.strobes[8]) m_stall <= m_stall + 1;
      if (e.redir) m_flush <= m_flush + 1;
      if (!m_halted && halt_wb) m_halted <= 1'b1;
      m_wait <= !m_halted && !halt_wb &&
                (m_wait ? !dhit : ((dmemREN_mem || dmemWEN_mem) && !dhit));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (cmp_on) begin
      exp_t e;
      e = model(m_halted, m_wait);
      chk("strobes", 32'({pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em, halt}),
          32'(e.strobes));
      chk("strobes_w4", 32'({pc_en4, en_fd4, en_de4, en_em4, en_mw4, flush_fd4, flush_de4,
          flush_em4, halt4}), 32'(e.strobes));
      chk("stall_cycles", stall_cycles, m_stall);
      chk("flush_count", flush_count, m_flush);
      chk("stall_w4", 32'(stall4), 32'(m_stall[3:0]));
      chk("flush_w4", 32'(flush4), 32'(m_flush[3:0]));
    end
  end

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; dmemREN_mem = 1'b0; dmemWEN_mem = 1'b0;
    memread_ex = 1'b0; regwen_ex = 1'b0; rd_ex = '0; rs_dec = '0; rt_dec = '0;
    redirect_ex = 1'b0; halt_wb = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle();
    nRST = 1'b0;
    @(negedge CLK);
    chk("rst_stall", stall_cycles, 32'd0);
    chk("rst_flush", flush_count, 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    tick();
    nRST = 1'b1;
  endtask

  initial begin
    idle();
    nRST = 1'b0;
    #2;
    cmp_on = 1'b1;
    do_reset();

    // Load-use: lw r5 in execute, decode reads r5
    memread_ex = 1'b1; regwen_ex = 1'b1; rd_ex = 5'd5; rs_dec = 5'd5; rt_dec = 5'd2;
    @(negedge CLK);
    chk("lu_pc_en", 32'(pc_en), 32'd0);
    chk("lu_en_fd", 32'(en_fd), 32'd0);
    chk("lu_flush_de", 32'(flush_de), 32'd1);
    chk("lu_en_em", 32'(en_em), 32'd1);
    tick(); idle();
    @(negedge CLK);
    chk("lu_after_pc_en", 32'(pc_en), 32'd1);
    chk("lu_stall", stall_cycles, 32'd1);

    // Data miss for three cycles, then release
    do_reset();
    dmemREN_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("dmiss_frozen", 32'({pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de}), 32'd0);
      tick();
    end
    dhit = 1'b1;
    @(negedge CLK);
    chk("dmiss_release_pc_en", 32'(pc_en), 32'd1);
    tick(); idle();
    @(negedge CLK);
    chk("dmiss_stall", stall_cycles, 32'd3);
    chk("dmiss_back_run", 32'(pc_en), 32'd1);

    // Redirect held across a two-cycle miss
    do_reset();
    dmemREN_mem = 1'b1; redirect_ex = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("rdw_no_flush", 32'({flush_fd, flush_de, pc_en}), 32'd0);
      tick();
    end
    dhit = 1'b1;
    @(negedge CLK);
    chk("rdw_release", 32'({pc_en, flush_fd, flush_de, en_fd, en_de}), 32'b11100);
    tick(); idle();
    @(negedge CLK);
    chk("rdw_flush_count", flush_count, 32'd1);

    // Instruction miss, then redirect on the second cycle
    do_reset();
    ihit = 1'b0;
    @(negedge CLK);
    chk("imiss_c1", 32'({pc_en, flush_fd, en_de}), 32'b011);
    tick();
    redirect_ex = 1'b1;
    @(negedge CLK);
    chk("imiss_c2", 32'({pc_en, flush_fd, flush_de, en_fd}), 32'b1110);
    tick(); idle();
    @(negedge CLK);
    chk("imiss_counts", {stall_cycles[15:0], flush_count[15:0]}, {16'd1, 16'd1});

    // Halt is sticky until reset
    do_reset();
    halt_wb = 1'b1;
    @(negedge CLK);
    chk("halt_seen", 32'({halt, pc_en}), 32'b10);
    tick(); idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("halt_hold", 32'({halt, pc_en, en_fd, en_de, en_em, en_mw}), 32'b100000);
      tick();
    end
    chk("halt_stall", stall_cycles, 32'd1);
    nRST = 1'b0;
    @(negedge CLK);
    chk("halt_rst", 32'({halt, pc_en}), 32'b01);
    chk("halt_rst_stall", stall_cycles, 32'd0);
    tick();
    nRST = 1'b1;

    // Seventeen stalls wrap a 4-bit counter to 1
    do_reset();
    ihit = 1'b0;
    repeat (17) tick();
    idle();
    @(negedge CLK);
    chk("wrap_w4", 32'(stall4), 32'd1);
    chk("wrap_w32", stall_cycles, 32'd17);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      nRST        = ($urandom_range(0, 149) != 0);
      ihit        = ($urandom_range(0, 4) != 0);
      dhit        = $urandom_range(0, 1) == 1;
      dmemREN_mem = ($urandom_range(0, 4) == 0);
      dmemWEN_mem = ($urandom_range(0, 4) == 0);
      memread_ex  = ($urandom_range(0, 2) == 0);
      regwen_ex   = ($urandom_range(0, 3) != 0);
      rd_ex       = 5'($urandom_range(0, 3));
      rs_dec      = 5'($urandom_range(0, 3));
      rt_dec      = 5'($urandom_range(0, 3));
      redirect_ex = ($urandom_range(0, 9) == 0);
      halt_wb     = ($urandom_range(0, 199) == 0);
    end
    tick();
    @(negedge CLK);
    cmp_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
